// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the core and its responder.
// Signal names keep the responder-side direction suffixes.
interface dmem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i,
    input  req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i,
    output req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states.
// Word RAM with byte lanes, sub-word loads extended on the access edge.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT0 =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [2**ADDR_W];

  logic        w_ready;
  logic        w_valid;
  logic        w_idle;
  logic        w_accept;
  logic        w_access;
  logic        w_we;
  logic        w_uns;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_sh;
  logic        w_oor;
  logic        w_err;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = bus.req_valid_i & w_ready;
  assign w_access = ((r_state == S_WAIT) && (r_cnt == 4'd0))
                  || (w_accept && !HAS_WAIT);

  // Zero-wait builds access the RAM on the accept edge, so
  // operands bypass the capture registers while idle.
  assign w_we    = w_idle ? bus.req_we_i       : r_we;
  assign w_uns   = w_idle ? bus.req_unsigned_i : r_uns;
  assign w_size  = w_idle ? bus.req_size_i     : r_size;
  assign w_addr  = w_idle ? bus.req_addr_i     : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata_i    : r_wdata;

  assign w_idx  = w_addr[ADDR_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {w_addr[1:0], 3'b000};
  assign w_oor  = |w_addr[31:ADDR_W+2];

  always_comb begin
    w_err  = 1'b1;
    w_load = 32'd0;
    w_be   = 4'b0000;
    w_wd   = 32'd0;
    unique case (w_size)
      2'b00: begin
        w_err  = w_oor;
        w_load = {{24{~w_uns & w_sh[7]}}, w_sh[7:0]};
        w_be   = 4'b0001 << w_addr[1:0];
        w_wd   = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_err  = w_oor | w_addr[0];
        w_load = {{16{~w_uns & w_sh[15]}}, w_sh[15:0]};
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd   = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_err  = w_oor | (|w_addr[1:0]);
        w_load = w_sh;
        w_be   = 4'b1111;
        w_wd   = w_wdata;
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept) w_next = HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT:
        if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:
        if (bus.rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_RESP:  w_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = w_valid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we_i;
        r_uns   <= bus.req_unsigned_i;
        r_size  <= bus.req_size_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
        r_cnt   <= CNT0;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      end else if (w_valid && bus.rsp_ready_i) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_access && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: directed requests push expected responses,
// per-DUT monitors pop and compare on each response handshake.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_if ifa ();
  dmem_if ifb ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(ifa.slave)
  );
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(ifb.slave)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   acc_a[$];
  int   acc_b[$];
  int   rsp_b_cyc[$];
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      acc_a.delete();
      pv_a = 1'b0;
    end else begin
      if (ifa.req_valid_i && ifa.req_ready_o) acc_a.push_back(cyc);
      if (ifa.rsp_valid_o && !pv_a) begin
        if (acc_a.size() == 0) chk("a_lat_noacc", 32'd1, 32'd0);
        else chk("a_latency", 32'(cyc - acc_a.pop_front()), 32'd3);
      end
      if (ifa.rsp_valid_o && ifa.rsp_ready_i) begin
        if (qa.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
        else begin
          x = qa.pop_front();
          chk("a_rdata", ifa.rsp_rdata_o, x.d);
          chk("a_err", 32'(ifa.rsp_err_o), 32'(x.e));
        end
      end
      pv_a = ifa.rsp_valid_o;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      acc_b.delete();
      pv_b = 1'b0;
    end else begin
      if (ifb.req_valid_i && ifb.req_ready_o) acc_b.push_back(cyc);
      if (ifb.rsp_valid_o && !pv_b) begin
        if (acc_b.size() == 0) chk("b_lat_noacc", 32'd1, 32'd0);
        else chk("b_latency", 32'(cyc - acc_b.pop_front()), 32'd1);
      end
      if (ifb.rsp_valid_o && ifb.rsp_ready_i) begin
        rsp_b_cyc.push_back(cyc);
        if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
        else begin
          x = qb.pop_front();
          chk("b_rdata", ifb.rsp_rdata_o, x.d);
          chk("b_err", 32'(ifb.rsp_err_o), 32'(x.e));
        end
      end
      pv_b = ifb.rsp_valid_o;
    end
  end

  task automatic issue(input bit b, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] er,
                       input bit ee);
    int n = 0;
    exp_t x;
    x.d = er;
    x.e = ee;
    if (!b) begin
      qa.push_back(x);
      ifa.req_we_i = we; ifa.req_size_i = sz; ifa.req_unsigned_i = uns;
      ifa.req_addr_i = ad; ifa.req_wdata_i = wd; ifa.req_valid_i = 1'b1;
      while (!ifa.req_ready_o && n < 100) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      ifa.req_valid_i = 1'b0;
      ifa.req_wdata_i = 32'hA5A5A5A5;
      ifa.req_addr_i  = 32'hFFFF_FFFF;
    end else begin
      qb.push_back(x);
      ifb.req_we_i = we; ifb.req_size_i = sz; ifb.req_unsigned_i = uns;
      ifb.req_addr_i = ad; ifb.req_wdata_i = wd; ifb.req_valid_i = 1'b1;
      while (!ifb.req_ready_o && n < 100) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      ifb.req_valid_i = 1'b0;
    end
    if (n >= 100) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    ifa.req_valid_i = 0; ifa.req_we_i = 0; ifa.req_size_i = 0;
    ifa.req_unsigned_i = 0; ifa.req_addr_i = 0; ifa.req_wdata_i = 0;
    ifa.rsp_ready_i = 1;
    ifb.req_valid_i = 0; ifb.req_we_i = 0; ifb.req_size_i = 0;
    ifb.req_unsigned_i = 0; ifb.req_addr_i = 0; ifb.req_wdata_i = 0;
    ifb.rsp_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("rst_valid", 32'(ifa.rsp_valid_o), 32'd0);
    chk("rst_rdata", ifa.rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(ifa.rsp_err_o), 32'd0);
    rst = 1'b0;

    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF7F, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0);
    issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    issue(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h00007FEF, 0);
    issue(0, 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b00, 0, 32'h11, 32'h0, 32'h0, 1 == 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD00EF, 0);
    issue(0, 1, 2'b01, 0, 32'h12, 32'h1234BEEF, 32'h0, 0);
    issue(0, 1, 2'b01, 0, 32'h13, 32'h0000AAAA, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hBEEF00EF, 0);
    issue(0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    drain();

    ifa.rsp_ready_i = 1'b0;
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);
    n = 0;
    while (!ifa.rsp_valid_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("bp_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(ifa.rsp_valid_o), 32'd1);
      chk("bp_rdata", ifa.rsp_rdata_o, 32'hCAFEF00D);
      chk("bp_err", 32'(ifa.rsp_err_o), 32'd0);
      chk("bp_req_ready", 32'(ifa.req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    ifa.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("post_hs_valid", 32'(ifa.rsp_valid_o), 32'd0);
    chk("post_hs_rdata", ifa.rsp_rdata_o, 32'd0);
    drain();

    ifa.req_we_i = 1; ifa.req_size_i = 2'b10; ifa.req_unsigned_i = 0;
    ifa.req_addr_i = 32'h20; ifa.req_wdata_i = 32'h12345678;
    ifa.req_valid_i = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid_i = 1'b0;
    chk("wait_ready", 32'(ifa.req_ready_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("mid_rst_valid", 32'(ifa.rsp_valid_o), 32'd0);
    chk("mid_rst_rdata", ifa.rsp_rdata_o, 32'd0);
    chk("mid_rst_err", 32'(ifa.rsp_err_o), 32'd0);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);
    drain();

    for (int i = 0; i < 4; i++)
      issue(1, 1, 2'b10, 0, 32'(4 * i), 32'h11111111 * (i + 1),
            32'h0, 0);
    drain();
    rsp_b_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.d = 32'h11111111 * (i + 1);
      x.e = 1'b0;
      qb.push_back(x);
    end
    ifb.req_we_i = 0; ifb.req_size_i = 2'b10; ifb.req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifb.req_addr_i = 32'(4 * i);
      n = 0;
      while (!ifb.req_ready_o && n < 20) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 20) chk("b_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    ifb.req_valid_i = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("b_rsp_count", 32'(rsp_b_cyc.size()), 32'd4);
    for (int i = 1; i < rsp_b_cyc.size(); i++)
      chk("b_period", 32'(rsp_b_cyc[i] - rsp_b_cyc[i-1]), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
